// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory.
//   dmem_state_e   : controller states (CLEAR, IDLE, WAIT, RESP)
//   WORD_W         : data word width in bits
//   BYTES_PER_WORD : byte lanes per word
//   BYTE_W         : width of one byte lane
//   WAIT_CNT_W     : width of the wait-state counter (0..15 extra cycles)
//   merge_lane()   : selects new or old data for one byte lane
package dmem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = WORD_W / BYTES_PER_WORD;
  localparam int WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_state_e;

  function automatic logic [BYTE_W-1:0] merge_lane(
    input logic              en,
    input logic [BYTE_W-1:0] new_byte,
    input logic [BYTE_W-1:0] old_byte
  );
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge for partial-word stores.
// Ports:
//   old_word : current memory word
//   wdata    : lane-aligned store data from the core
//   byteen   : per-lane write enables (bit k selects bits [8k+7:8k])
//   merged   : old_word with enabled lanes replaced by wdata
module dmem_byte_merge
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0]         old_word,
  input  logic [WORD_W-1:0]         wdata,
  input  logic [BYTES_PER_WORD-1:0] byteen,
  output logic [WORD_W-1:0]         merged
);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      merged[k*BYTE_W +: BYTE_W] = merge_lane(byteen[k],
                                              wdata[k*BYTE_W +: BYTE_W],
                                              old_word[k*BYTE_W +: BYTE_W]);
    end
  end

endmodule

// File: rtl/dmem_wait_mem.sv
// Byte-enabled data memory with programmable wait states for the pipelined
// MIPS core. After reset the array is zeroed one word per cycle, then
// requests are accepted one at a time with a valid/ready handshake and
// complete with a single-cycle resp_valid pulse WAIT_CYCLES+2 cycles later.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   BASE_ADDR   : byte address of word 0 (word-aligned)
//   WAIT_CYCLES : extra cycles between accept and commit (0..15)
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid / req_ready      : request handshake (ready only when idle)
//   req_addr                   : byte address, bits [1:0] ignored
//   req_byteen                 : lane write enables, 0 = read
//   req_wdata                  : lane-aligned write data
//   req_pc                     : requesting instruction address (trace only)
//   resp_valid                 : one-cycle completion pulse
//   resp_rdata                 : read word (0 for writes and errors), held
//   resp_err                   : address out of range, held
//
// Build option: define DMEM_TRACE_EN to print one line per successful write
// commit: "<time>@<pc>: *<word addr> <= <merged word>".
module dmem_wait_mem
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [29:0]           BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0]           DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_e state, state_next;

  logic [IDX_W-1:0]      clear_ptr;
  logic [WAIT_CNT_W-1:0] cnt;

  // Request fields captured at accept; the core may change req_* afterwards.
  logic [29:0]           lat_word;
  logic [3:0]            lat_byteen;
  logic [31:0]           lat_wdata;

  logic [WORD_W-1:0]     mem [DEPTH_WORDS];

  logic                  accept;
  logic                  commit;
  logic [29:0]           word_off;
  logic                  addr_err;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     old_word;
  logic [WORD_W-1:0]     merged;
  logic                  unused_addr_lsb;

  // BASE_ADDR is word-aligned, so decoding on word addresses is exact and
  // the byte-offset bits of the request never matter.
  assign unused_addr_lsb = ^req_addr[1:0];

  assign accept   = req_valid && (state == IDLE);
  assign commit   = (state == WAIT) && (cnt == '0);
  assign word_off = lat_word - BASE_WORD;
  // Below-base addresses wrap word_off, so they are rejected explicitly.
  assign addr_err = (lat_word < BASE_WORD) || (word_off >= DEPTH_W30);
  assign idx      = word_off[IDX_W-1:0];
  assign old_word = mem[idx];

  dmem_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (lat_wdata),
    .byteen   (lat_byteen),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      CLEAR: begin
        if (clear_ptr == LAST_IDX) state_next = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_ptr  <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == CLEAR) clear_ptr <= clear_ptr + 1'b1;

      if (accept) begin
        cnt <= WAIT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (commit) begin
        if (addr_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else if (lat_byteen == '0) begin
          resp_err   <= 1'b0;
          resp_rdata <= old_word;
        end else begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      end
    end
  end

  // Request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_word   <= req_addr[31:2];
      lat_byteen <= req_byteen;
      lat_wdata  <= req_wdata;
    end
  end

  // Array write port: clear sweep or committed store; reset blocks both so
  // an in-flight request is dropped without touching memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clear_ptr] <= '0;
      end else if (commit && !addr_err && (lat_byteen != '0)) begin
        mem[idx] <= merged;
      end
    end
  end

`ifdef DMEM_TRACE_EN
  logic [31:0] lat_pc;

  always_ff @(posedge clk) begin
    if (accept) lat_pc <= req_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && !addr_err && (lat_byteen != '0)) begin
      $display("%d@%h: *%h <= %h", $time, lat_pc, {lat_word, 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dmem_wait_mem.sv
module tb_dmem_wait_mem;

  localparam int DEPTH = 16;
  localparam int WAITC = 2;
  localparam int LAT   = WAITC + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_byteen = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  dmem_wait_mem #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: flat word array, spec-level decode and lane merge.
  task automatic model_req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e);
    int idx;
    if (a >= 32'(DEPTH * 4)) begin
      e  = 1'b1;
      rd = '0;
    end else begin
      idx = int'(a / 4);
      e   = 1'b0;
      if (be == 4'b0000) begin
        rd = model_mem[idx];
      end else begin
        for (int k = 0; k < 4; k++)
          if (be[k]) model_mem[idx][8*k +: 8] = wd[8*k +: 8];
        rd = '0;
      end
    end
  endtask

  // Starts and ends on a falling edge. lat counts rising edges after the
  // accept edge until resp_valid is seen.
  task automatic do_req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] pc, output logic [31:0] rd, output logic e,
                        output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_byteen = be;
    req_wdata  = wd;
    req_pc     = pc;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_byteen = 4'($urandom);
    req_wdata  = $urandom;
    req_pc     = $urandom;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    e  = resp_err;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        e, exp_e;
    int          lat, n;
    logic        saw_resp;
    logic [31:0] a, wd;
    logic [3:0]  be;

    vecs[0]  = '{32'h0000_0000, 4'b0000, 32'h0,          32'h0000_0000, 1'b0};
    vecs[1]  = '{32'h0000_0008, 4'b1111, 32'h1234_5678,  32'h0000_0000, 1'b0};
    vecs[2]  = '{32'h0000_0008, 4'b0000, 32'h0,          32'h1234_5678, 1'b0};
    vecs[3]  = '{32'h0000_0009, 4'b0010, 32'h0000_AB00,  32'h0000_0000, 1'b0};
    vecs[4]  = '{32'h0000_0008, 4'b0000, 32'h0,          32'h1234_AB78, 1'b0};
    vecs[5]  = '{32'h0000_0040, 4'b1111, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h0000_0000, 4'b0000, 32'h0,          32'h0000_0000, 1'b0};
    vecs[7]  = '{32'h0000_003C, 4'b0000, 32'h0,          32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h0000_0040, 4'b0000, 32'h0,          32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h0000_003C, 4'b1001, 32'hA1B2_C3D4,  32'h0000_0000, 1'b0};
    vecs[10] = '{32'h0000_003E, 4'b0000, 32'h0,          32'hA100_00D4, 1'b0};
    vecs[11] = '{32'hFFFF_FFFC, 4'b0000, 32'h0,          32'h0000_0000, 1'b1};
    vecs[12] = '{32'h0000_0000, 4'b0100, 32'h0077_0000,  32'h0000_0000, 1'b0};
    vecs[13] = '{32'h0000_0001, 4'b0000, 32'h0,          32'h0077_0000, 1'b0};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset for two cycles, check reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready",  {31'b0, req_ready},  32'd0);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_rdata", resp_rdata,          32'd0);
    chk("reset_resp_err",   {31'b0, resp_err},   32'd0);

    // Clear sweep: a write held on req_valid during CLEAR must be ignored
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    req_byteen = 4'b1111;
    req_wdata  = 32'h5555_AAAA;
    n = 0;
    saw_resp = 1'b0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (resp_valid) saw_resp = 1'b1;
      if (req_ready) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("clear_cycles", 32'(n), 32'(DEPTH));
    chk("clear_no_resp", {31'b0, saw_resp}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].addr, vecs[i].be, vecs[i].wd, 32'h0000_1000 + 32'(i * 4), rd, e, lat);
      model_req(vecs[i].addr, vecs[i].be, vecs[i].wd, exp_rd, exp_e);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("vec%0d_pulse_end", i), {31'b0, resp_valid}, 32'd0);
      chk($sformatf("vec%0d_rdata_hold", i), resp_rdata, vecs[i].exp_rd);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      a  = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'($urandom_range(0, 79));
      be = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      wd = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_req(a, be, wd, exp_rd, exp_e);
      do_req(a, be, wd, $urandom, rd, e, lat);
      chk($sformatf("rnd%0d_rdata a=%h be=%b", i, a, be), rd, exp_rd);
      chk($sformatf("rnd%0d_err a=%h", i, a), {31'b0, e}, {31'b0, exp_e});
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(LAT));
    end

    // Traced store
    model_req(32'h4, 4'b1111, 32'hDEAD_BEEF, exp_rd, exp_e);
    do_req(32'h4, 4'b1111, 32'hDEAD_BEEF, 32'h0000_3004, rd, e, lat);
    chk("trace_write_err", {31'b0, e}, 32'd0);
    do_req(32'h4, 4'b0000, 32'h0, 32'h0, rd, e, lat);
    chk("trace_readback", rd, 32'hDEAD_BEEF);

    // Reset during WAIT aborts the request and restarts the sweep
    do_req(32'h4, 4'b1111, 32'h1111_1111, 32'h0, rd, e, lat);
    do_req(32'h4, 4'b0000, 32'h0, 32'h0, rd, e, lat);
    chk("pre_abort_read", rd, 32'h1111_1111);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_addr   = 32'h4;
    req_byteen = 4'b1111;
    req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    n = 0;
    saw_resp = 1'b0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("abort_clear_cycles", 32'(n), 32'(DEPTH));
    chk("abort_no_resp", {31'b0, saw_resp}, 32'd0);
    do_req(32'h4, 4'b0000, 32'h0, 32'h0, rd, e, lat);
    chk("abort_read_0x4", rd, 32'h0);
    chk("abort_read_0x4_err", {31'b0, e}, 32'd0);
    do_req(32'h3C, 4'b0000, 32'h0, 32'h0, rd, e, lat);
    chk("abort_read_0x3c", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_wait_mem.md
Name: dmem_wait_mem

Overview:
Parametrised, synthesizable byte-enabled data memory for the pipelined MIPS core.
- Generalises the bench-level data array:
  - configurable depth and base address;
  - programmable wait states;
  - valid/ready request handshake;
  - out-of-range error reporting;
  - sequential post-reset clear sweep.
- Sits between the M stage (m_data_addr / m_data_wdata / m_data_byteen) and the core's stall logic.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; power of two, ≥ 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.
WAIT_CYCLES, 0, extra cycles between accept and commit; range 0..15.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_addr  input  32  byte address; bits [1:0] ignored.
req_byteen  input  4  byte write enables; 4'b0000 means read.
req_wdata  input  32  write data, already lane-shifted by the core.
req_pc  input  32  instruction address of the request, used for trace only.
resp_valid  output  1  single-cycle completion pulse.
resp_rdata  output  32  read word; 0 for writes and errors.
resp_err  output  1  address out of range; qualified by resp_valid.

Behaviour:
- State machine: CLEAR, IDLE, WAIT, RESP.
- Reset (reset=1 at an edge):
  - state←CLEAR, clear_ptr←0;
  - resp_rdata←0, resp_err←0;
  - any in-flight request is aborted: no commit, no resp_valid.
  - reset dominates every other event.
- CLEAR:
  - each cycle writes 0 to mem[clear_ptr] and increments clear_ptr;
  - at clear_ptr==DEPTH_WORDS-1 the edge writes the last word and moves to IDLE;
  - req_ready=0 for exactly DEPTH_WORDS cycles after reset is released.
- Outputs by state:
  - req_ready=1 only in IDLE;
  - resp_valid=1 only in RESP (decoded from the registered state).
- IDLE, accept (req_valid && req_ready at edge T):
  - latch addr, byteen, wdata, pc;
  - cnt←WAIT_CYCLES; state←WAIT.
- WAIT:
  - if cnt≠0: cnt←cnt-1.
  - if cnt==0: commit and state←RESP.
  - The commit edge is T+1+WAIT_CYCLES.
  - resp_valid is high for the one cycle after the commit edge.
  - Throughput is one request per WAIT_CYCLES+3 cycles.
- Address decode:
  - idx = (addr-BASE_ADDR)>>2;
  - error if addr<BASE_ADDR or idx≥DEPTH_WORDS.
- Commit, error case: resp_err←1, resp_rdata←0, memory untouched.
- Commit, read (byteen==0): resp_rdata←mem[idx], resp_err←0.
- Commit, write (byteen≠0):
  - merged[8k+7:8k] = byteen[k] ? wdata[8k+7:8k] : mem[idx][8k+7:8k];
  - mem[idx]←merged; resp_rdata←0; resp_err←0.
- RESP: always returns to IDLE after one cycle. No response back-pressure; the core must stall until resp_valid.
- resp_rdata and resp_err hold their values until the next commit or reset.
- req_valid is ignored outside IDLE. req_* inputs are ignored after accept, since they are latched.

Optional Feature:
DMEM_TRACE_EN
- Defined:
  - on every successful write commit, $display("%d@%h: *%h <= %h", $time, latched pc, word-aligned addr, merged word);
  - no line is printed for reads, errors or CLEAR writes.
- Undefined:
  - no simulation output;
  - req_pc is unused but the port remains.

Decomposition:
- Package dmem_pkg:
  - state enum {CLEAR, IDLE, WAIT, RESP};
  - BYTES_PER_WORD=4;
  - WORD_W=32;
  - byte-merge function prototype constants.
- One sub-module, dmem_byte_merge:
  - purely combinational;
  - inputs old word, wdata, byteen; output merged word.
- Top module holds the state machine, counter, clear sweep and array.

Test Plan:
All scenarios use DEPTH_WORDS=16, WAIT_CYCLES=2, BASE_ADDR=0.
1. Reset 2 cycles, release → req_ready low exactly 16 cycles then high; read 0x0 → resp_rdata=0x00000000, resp_err=0.
2. Write 0x12345678 @0x8 byteen 4'b1111, accepted at edge T → resp_valid high only in cycle after edge T+3; then read 0x8 → 0x12345678.
3. Write 0x0000AB00 @0x9 byteen 4'b0010 → read 0x8 → 0x1234AB78; bits [1:0] of the address are ignored.
4. Write 0xFFFFFFFF @0x40 byteen 4'b1111 → resp_err=1, resp_rdata=0; read 0x0 still 0x00000000; read 0x3C → resp_err=0, 0x00000000.
5. Write 0xCAFEF00D @0x4 accepted, reset asserted in the first WAIT cycle → no resp_valid; CLEAR repeats 16 cycles; read 0x4 → 0x00000000.
6. With DMEM_TRACE_EN: write 0xDEADBEEF @0x4, pc 0x00003004 → exactly one trace line "@00003004: *00000004 <= deadbeef". Without the macro → no output.
